countdown_timer: RTL and testbench
==================================

// Module: countdown_timer
// PURPOSE
//   Loadable down-counter/timer that complements the up-counting Counter block.
//   Counts from a runtime-loaded value down to zero by STEP per enabled cycle.
//   Raises a one-cycle terminal-count pulse when it reaches zero.
//   Used for timeouts, delay generation and burst-length tracking in digital control logic.
// PARAMETERS
//   WIDTH = 8 : bit width of the count value and of LOAD_VAL
//   STEP  = 1 : decrement per enabled cycle, 1..2**WIDTH-1
// PORTS
//   CLK       in   1      clock; all state updates on posedge CLK
//   RESET     in   1      asynchronous, active-high reset
//   LOAD      in   1      load LOAD_VAL and start counting (one-cycle strobe)
//   LOAD_VAL  in   WIDTH  start value, sampled when LOAD=1
//   EN        in   1      count enable; decrement only when EN=1 in RUN
//   out       out  WIDTH  current count value (registered)
//   TC        out  1      terminal-count pulse (registered)
//   BUSY      out  1      1 while in RUN state
// BEHAVIOUR
//   Interface: one clock (CLK); RESET is asynchronous, active-high.
//   Reset (async, any time, including mid-count):
//   - out=0, TC=0, BUSY=0, reload register=0, state=IDLE.
//   States: IDLE (never loaded / loaded with 0), RUN, DONE.
//   BUSY=1 iff state==RUN, taken from the state register, so it is glitch-free.
//   LOAD=1, any state:
//   - out<=LOAD_VAL and reload register<=LOAD_VAL.
//   - Next state: RUN if LOAD_VAL!=0, else IDLE with TC=0.
//   - LOAD has priority over EN in the same cycle: no decrement that cycle.
//   RUN, EN=0: out holds; TC=0.
//   RUN, EN=1, out>STEP: out<=out-STEP; TC=0.
//   RUN, EN=1, out<=STEP (terminal):
//   - out<=0 (saturates, never wraps below zero); TC<=1 for exactly one cycle.
//   - Next state DONE (see CONFIGURATION for the auto-reload case).
//   DONE: out holds 0, TC=0, BUSY=0. EN is ignored. Only LOAD or RESET leaves DONE.
//   IDLE: out holds its value; EN is ignored.
//   Arithmetic: the subtract is WIDTH bits wide, with the compare done before the
//     subtract, so no underflow is possible.
//   Latency: out reflects LOAD_VAL 1 cycle after the LOAD edge.
//     With STEP=1 and EN held high, TC asserts on the Nth enabled edge after load
//     (N = LOAD_VAL), on the same edge that out becomes 0.
//   TC is never asserted on two consecutive cycles unless auto-reload is enabled
//     and the reload value is <=STEP.
// CONFIGURATION
//   Macro: COUNTDOWN_TIMER_AUTORELOAD_EN
//   Defined:
//   - At terminal, out<=reload register (not 0), TC pulses 1 cycle, state stays RUN.
//     This gives a periodic TC every ceil(R/STEP) enabled cycles, where R is the
//     reload value.
//   - DONE is unreachable.
//   - If the reload register is 0 the block enters IDLE instead, since LOAD_VAL=0
//     never enters RUN.
//   Not defined: one-shot behaviour as in BEHAVIOUR (terminal -> DONE, out=0).
// TESTING
//   1 Reset mid-count: LOAD_VAL=20, run 5 cycles, pulse RESET asynchronously
//     between edges -> out=0, TC=0 and BUSY=0 immediately; IDLE afterwards.
//   2 One-shot: STEP=1, LOAD_VAL=5, EN=1 held -> out 5,4,3,2,1,0; TC=1 only on
//     the edge where out becomes 0; BUSY falls on that same edge; out stays 0
//     for 10 more cycles.
//   3 Non-unit step: STEP=3, LOAD_VAL=7 -> out 7,4,1,0 (saturates, no wrap to
//     254); TC pulses once.
//   4 Priority/hold: LOAD and EN together -> out=LOAD_VAL, no decrement;
//     EN=0 for 4 cycles in RUN -> out unchanged;
//     LOAD_VAL=0 -> IDLE, BUSY=0, TC never asserts.
//   5 Auto-reload (macro defined): STEP=1, LOAD_VAL=3 -> out 3,2,1,3,2,1,...;
//     TC pulses every 3rd enabled cycle; BUSY stays 1.
//   6 Reload mid-run: LOAD_VAL=9 while out=4 -> out=9 next cycle, count restarts
//     from 9, no TC is emitted for the aborted count.

Source files
------------

// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
//   Loadable down-counter / timer. A LOAD strobe captures LOAD_VAL into both
//   the count register and the reload register and starts a countdown. Each
//   enabled cycle in RUN subtracts STEP. On reaching zero (or when the
//   remaining count is at most STEP) the counter saturates to zero, emits a
//   one-cycle TC pulse and parks in DONE.
//
//   Optional feature macro: COUNTDOWN_TIMER_AUTORELOAD_EN
//     When defined, the terminal cycle reloads the count from the reload
//     register and stays in RUN, giving a periodic TC. DONE is unreachable.
//     When undefined (default), the timer is one-shot.
//
//   Reset is asynchronous and active-high; all other state changes happen on
//   the rising edge of CLK.
// -----------------------------------------------------------------------------
module countdown_timer #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VAL,
    input  logic             EN,
    output logic [WIDTH-1:0] out,
    output logic             TC,
    output logic             BUSY
);

    // STEP is brought to the datapath width once, so the compare and the
    // subtract below both operate on WIDTH-bit quantities.
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] count_q,  count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q,     tc_d;

    // The compare is taken before the subtract: the subtract result is only
    // used when count_q is strictly greater than STEP, so it cannot underflow.
    logic             at_terminal;
    logic [WIDTH-1:0] count_minus_step;

    assign at_terminal      = (count_q <= STEP_W);
    assign count_minus_step = count_q - STEP_W;

    // Next-state and next-output logic; LOAD wins over every other condition.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;

        if (LOAD) begin
            count_d  = LOAD_VAL;
            reload_d = LOAD_VAL;
            state_d  = (LOAD_VAL != '0) ? ST_RUN : ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    // Never loaded, or loaded with zero: hold, ignore EN.
                    count_d = count_q;
                end

                ST_RUN: begin
                    if (EN) begin
                        if (!at_terminal) begin
                            count_d = count_minus_step;
                        end else begin
                            tc_d = 1'b1;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
                            // Periodic mode: restart from the reload value.
                            // A zero reload value cannot restart a count.
                            count_d = reload_q;
                            state_d = (reload_q != '0) ? ST_RUN : ST_IDLE;
`else
                            // One-shot mode: saturate at zero and park.
                            count_d = '0;
                            state_d = ST_DONE;
`endif
                        end
                    end
                end

                ST_DONE: begin
                    // Only LOAD (handled above) or RESET leaves DONE.
                    count_d = '0;
                end

                default: begin
                    // Unused encoding: recover to a safe idle state.
                    state_d = ST_IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    // State, count, reload and TC registers with asynchronous reset.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    // All outputs come straight from registers, so they are glitch-free.
    assign out  = count_q;
    assign TC   = tc_q;
    assign BUSY = (state_q == ST_RUN);

endmodule

// File: tb/tb_countdown_timer.sv
// -----------------------------------------------------------------------------
// tb_countdown_timer
//   Directed bench for countdown_timer. Two instances are used: one with
//   STEP=1 and one with STEP=3, both WIDTH=8. Inputs are driven 1 time unit
//   after the rising edge and outputs are sampled at the same point, i.e.
//   well away from the active edge.
// -----------------------------------------------------------------------------
module tb_countdown_timer;

`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       clk;
    logic       rst;

    logic       load1, en1;
    logic [7:0] val1;
    logic [7:0] out1;
    logic       tc1, busy1;

    logic       load3, en3;
    logic [7:0] val3;
    logic [7:0] out3;
    logic       tc3, busy3;

    int checks   = 0;
    int failures = 0;
    int tc_count;

    countdown_timer #(.WIDTH(8), .STEP(1)) dut1 (
        .CLK      (clk),
        .RESET    (rst),
        .LOAD     (load1),
        .LOAD_VAL (val1),
        .EN       (en1),
        .out      (out1),
        .TC       (tc1),
        .BUSY     (busy1)
    );

    countdown_timer #(.WIDTH(8), .STEP(3)) dut3 (
        .CLK      (clk),
        .RESET    (rst),
        .LOAD     (load3),
        .LOAD_VAL (val3),
        .EN       (en3),
        .out      (out3),
        .TC       (tc3),
        .BUSY     (busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and land 1 unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        $display("t=%0t dut1 out=%0d tc=%0b busy=%0b | dut3 out=%0d tc=%0b busy=%0b",
                 $time, out1, tc1, busy1, out3, tc3, busy3);
    endtask

    task automatic chk1(input string tag, input int o, input int t, input int b);
        chk({tag, ".out"},  32'(out1),  o);
        chk({tag, ".tc"},   32'(tc1),   t);
        chk({tag, ".busy"}, 32'(busy1), b);
    endtask

    task automatic chk3(input string tag, input int o, input int t, input int b);
        chk({tag, ".out"},  32'(out3),  o);
        chk({tag, ".tc"},   32'(tc3),   t);
        chk({tag, ".busy"}, 32'(busy3), b);
    endtask

    initial begin
        rst = 1'b1;
        load1 = 1'b0; en1 = 1'b0; val1 = 8'd0;
        load3 = 1'b0; en3 = 1'b0; val3 = 8'd0;

        // ---- Reset state ----
        #2;
        chk1("rst1", 0, 0, 0);
        chk3("rst3", 0, 0, 0);
        step();
        step();
        rst = 1'b0;

        // ---- EN ignored in IDLE ----
        en1 = 1'b1;
        step();
        chk1("idle_en", 0, 0, 0);

        // ---- One-shot countdown, STEP=1, LOAD_VAL=5 ----
        load1 = 1'b1; val1 = 8'd5; en1 = 1'b1;
        step();
        chk1("os_load", 5, 0, 1);
        load1 = 1'b0;
        for (int k = 4; k >= 1; k--) begin
            step();
            chk1("os_cnt", k, 0, 1);
        end
        step();
        chk1("os_term", AR ? 5 : 0, 1, AR ? 1 : 0);
        if (!AR) begin
            for (int k = 0; k < 10; k++) begin
                step();
                chk1("os_done", 0, 0, 0);
            end
        end

        // ---- LOAD has priority over EN; EN=0 holds ----
        load1 = 1'b1; val1 = 8'd10; en1 = 1'b1;
        step();
        chk1("pri_load", 10, 0, 1);
        load1 = 1'b0;
        step();
        chk1("pri_dec", 9, 0, 1);
        load1 = 1'b1; val1 = 8'd6;
        step();
        chk1("pri_nodec", 6, 0, 1);
        load1 = 1'b0; en1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk1("hold_en0", 6, 0, 1);
        end

        // ---- LOAD_VAL=0 goes to IDLE, no TC ----
        load1 = 1'b1; val1 = 8'd0; en1 = 1'b1;
        step();
        chk1("zero_load", 0, 0, 0);
        load1 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk1("zero_idle", 0, 0, 0);
        end

        // ---- Reload mid-run: 8 -> 4, reload 9, single TC ----
        load1 = 1'b1; val1 = 8'd8; en1 = 1'b1;
        step();
        chk1("mid_load8", 8, 0, 1);
        load1 = 1'b0;
        for (int k = 7; k >= 4; k--) begin
            step();
            chk1("mid_cnt", k, 0, 1);
        end
        load1 = 1'b1; val1 = 8'd9;
        step();
        chk1("mid_load9", 9, 0, 1);
        load1 = 1'b0;
        tc_count = 0;
        for (int k = 8; k >= 1; k--) begin
            step();
            chk1("mid_cnt9", k, 0, 1);
            tc_count += int'(tc1);
        end
        step();
        chk1("mid_term", AR ? 9 : 0, 1, AR ? 1 : 0);
        tc_count += int'(tc1);
        chk("mid_tc_count", 32'(tc_count), 1);

        // ---- STEP=3: 7,4,1,0 saturating ----
        load3 = 1'b1; val3 = 8'd7; en3 = 1'b1;
        step();
        chk3("s3_load", 7, 0, 1);
        load3 = 1'b0;
        step();
        chk3("s3_4", 4, 0, 1);
        step();
        chk3("s3_1", 1, 0, 1);
        step();
        chk3("s3_term", AR ? 7 : 0, 1, AR ? 1 : 0);
        if (!AR) begin
            step();
            chk3("s3_done", 0, 0, 0);
        end

        // ---- STEP=3 boundary: count equal to STEP is terminal ----
        load3 = 1'b1; val3 = 8'd3;
        step();
        chk3("s3eq_load", 3, 0, 1);
        load3 = 1'b0;
        step();
        chk3("s3eq_term", AR ? 3 : 0, 1, AR ? 1 : 0);
        en3 = 1'b0;

        // ---- Auto-reload periodic TC ----
        if (AR) begin
            load1 = 1'b1; val1 = 8'd3; en1 = 1'b1;
            step();
            chk1("ar_load", 3, 0, 1);
            load1 = 1'b0;
            for (int r = 0; r < 3; r++) begin
                step();
                chk1("ar_2", 2, 0, 1);
                step();
                chk1("ar_1", 1, 0, 1);
                step();
                chk1("ar_3", 3, 1, 1);
            end
        end

        // ---- Asynchronous reset mid-count ----
        load1 = 1'b1; val1 = 8'd20; en1 = 1'b1;
        step();
        chk1("ar20_load", 20, 0, 1);
        load1 = 1'b0;
        for (int k = 19; k >= 15; k--) begin
            step();
            chk1("ar20_cnt", k, 0, 1);
        end
        #2;
        rst = 1'b1;
        #1;
        chk1("async_rst", 0, 0, 0);
        #1;
        rst = 1'b0;
        step();
        chk1("post_rst_idle", 0, 0, 0);
        step();
        chk1("post_rst_idle2", 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
